// File: rtl/vol_ind_pkg.sv
// Shared types and helpers for the volume indicator: FSM states, the
// magnitude saturator, the thermometer encoder and the per-LED level step.
package vol_ind_pkg;

   localparam int VI_SAMPLE_W = 16;
   localparam int VI_NUM_LEDS = 8;
   localparam int STEP        = (2 ** (VI_SAMPLE_W - 1)) / VI_NUM_LEDS;

   typedef enum logic [0:0] {
      ACCUM  = 1'b0,
      UPDATE = 1'b1
   } state_t;

   // |s| for a two's complement sample; the most negative code clips to full scale
   function automatic logic [VI_SAMPLE_W-2:0] abs_sat(input logic [VI_SAMPLE_W-1:0] s);
      logic [VI_SAMPLE_W-1:0] neg;
      neg = ~s + VI_SAMPLE_W'(1);
      if (s[VI_SAMPLE_W-1] == 1'b0) begin
         return s[VI_SAMPLE_W-2:0];
      end else if (s == {1'b1, {(VI_SAMPLE_W-1){1'b0}}}) begin
         return {(VI_SAMPLE_W-1){1'b1}};
      end else begin
         return neg[VI_SAMPLE_W-2:0];
      end
   endfunction

   function automatic logic [VI_NUM_LEDS-1:0] to_thermo(input int n);
      logic [VI_NUM_LEDS-1:0] t;
      t = '0;
      for (int i = 0; i < VI_NUM_LEDS; i++) begin
         t[i] = (i < n);
      end
      return t;
   endfunction

endpackage

// File: rtl/volume_bar_decoder.sv
// Turns each window mean into a lit-LED count, applies peak-hold with
// windowed decay, and registers level, level_valid and the LED bar.
module volume_bar_decoder
   import vol_ind_pkg::*;
#(
   parameter int SAMPLE_W      = 16,
   parameter int NUM_LEDS      = 8,
   parameter int DECAY_WINDOWS = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                upd,
   input  logic [SAMPLE_W-1:0] mean,
   output logic [SAMPLE_W-1:0] level,
   output logic                level_valid,
   output logic [NUM_LEDS-1:0] leds
);

   localparam int LIT_W = $clog2(NUM_LEDS + 1);
   localparam int DEC_W = $clog2(DECAY_WINDOWS + 1);

   logic [LIT_W-1:0] held_r;
   logic [DEC_W-1:0] decay_r;
   logic [LIT_W-1:0] lit_s;
   logic [LIT_W-1:0] held_next_s;
   logic [DEC_W-1:0] decay_next_s;

   // Lit count for the new mean and the resulting peak-hold/decay next state
   always_comb begin
      lit_s        = '0;
      held_next_s  = held_r;
      decay_next_s = decay_r;
      for (int i = 0; i < NUM_LEDS; i++) begin
         if ({{(32-SAMPLE_W){1'b0}}, mean} > 32'(i * STEP)) begin
            lit_s = lit_s + LIT_W'(1);
         end else begin
            lit_s = lit_s;
         end
      end
      if (lit_s >= held_r) begin
         held_next_s  = lit_s;
         decay_next_s = '0;
      end else if (decay_r == DEC_W'(DECAY_WINDOWS - 1)) begin
         held_next_s  = held_r - LIT_W'(1);
         decay_next_s = '0;
      end else begin
         held_next_s  = held_r;
         decay_next_s = decay_r + DEC_W'(1);
      end
   end

   // Output and peak-hold registers, advanced once per completed window
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         level       <= '0;
         level_valid <= 1'b0;
         leds        <= '0;
         held_r      <= '0;
         decay_r     <= '0;
      end else begin
         level_valid <= upd;
         if (upd) begin
            level   <= mean;
            held_r  <= held_next_s;
            decay_r <= decay_next_s;
            leds    <= NUM_LEDS'(to_thermo(int'(held_next_s)));
         end
      end
   end

endmodule

// File: rtl/volume_indicator.sv
// Windowed mean-magnitude volume meter: accumulates |sample| over 2^LOG2_WIN
// accepted samples and hands each window mean to the LED bar decoder.
module volume_indicator
   import vol_ind_pkg::*;
#(
   parameter int SAMPLE_W      = 16,
   parameter int LOG2_WIN      = 8,
   parameter int NUM_LEDS      = 8,
   parameter int DECAY_WINDOWS = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                enable,
   input  logic                sample_valid,
   input  logic [SAMPLE_W-1:0] audio_in,
   output logic [SAMPLE_W-1:0] level,
   output logic                level_valid,
   output logic [NUM_LEDS-1:0] leds
);

   localparam int ACC_W = SAMPLE_W - 1 + LOG2_WIN;

   state_t              state_r;
   logic [ACC_W-1:0]    acc_r;
   logic [LOG2_WIN-1:0] cnt_r;
   logic [SAMPLE_W-1:0] mean_r;
   logic                upd_r;
   logic                accept_s;
   logic [ACC_W-1:0]    mag_ext_s;

   assign accept_s  = sample_valid & enable;
   assign mag_ext_s = {{LOG2_WIN{1'b0}}, abs_sat(audio_in)};

   // Window FSM; a sample arriving during UPDATE seeds the next window
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r <= ACCUM;
         acc_r   <= '0;
         cnt_r   <= '0;
         mean_r  <= '0;
         upd_r   <= 1'b0;
      end else begin
         upd_r <= 1'b0;
         case (state_r)
            ACCUM: begin
               if (accept_s) begin
                  acc_r <= acc_r + mag_ext_s;
                  cnt_r <= cnt_r + LOG2_WIN'(1);
                  if (cnt_r == {LOG2_WIN{1'b1}}) begin
                     state_r <= UPDATE;
                  end
               end
            end
            UPDATE: begin
               mean_r  <= {1'b0, acc_r[ACC_W-1 -: (SAMPLE_W-1)]};
               upd_r   <= 1'b1;
               state_r <= ACCUM;
               if (accept_s) begin
                  acc_r <= mag_ext_s;
                  cnt_r <= LOG2_WIN'(1);
               end else begin
                  acc_r <= '0;
                  cnt_r <= '0;
               end
            end
            default: begin
               state_r <= ACCUM;
            end
         endcase
      end
   end

   volume_bar_decoder #(
      .SAMPLE_W      (SAMPLE_W),
      .NUM_LEDS      (NUM_LEDS),
      .DECAY_WINDOWS (DECAY_WINDOWS)
   ) u_bar (
      .clk         (clk),
      .reset_n     (reset_n),
      .upd         (upd_r),
      .mean        (mean_r),
      .level       (level),
      .level_valid (level_valid),
      .leds        (leds)
   );

endmodule

// File: tb/tb_volume_indicator.sv
// Bench for volume_indicator with 4-sample windows: a behavioural model
// (accept counting + window queue) checked every cycle, plus directed literals.
module tb_volume_indicator;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b1;
   logic        sample_valid = 1'b0;
   logic [15:0] audio_in = 16'd0;
   logic [15:0] level;
   logic        level_valid;
   logic [7:0]  leds;

   int checks = 0;
   int errors = 0;
   int lv_count = 0;
   bit chk_en = 1'b0;

   volume_indicator #(.LOG2_WIN(2)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .sample_valid (sample_valid),
      .audio_in     (audio_in),
      .level        (level),
      .level_valid  (level_valid),
      .leds         (leds)
   );

   always #5 clk = ~clk;

   // Model state
   int cyc = 0;
   int m_level = 0, m_lv = 0, m_leds = 0;
   int held = 0, streak = 0, nacc = 0, sum = 0;
   int due_q[$];
   int mean_q[$];

   function automatic int mag_of(input logic [15:0] v);
      int s;
      s = $signed(v);
      if (s == -32768) return 32767;
      return (s < 0) ? -s : s;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: every 4th accept closes a window, visible 2 edges later
   always @(posedge clk) begin
      int n;
      cyc++;
      if (!reset_n) begin
         m_level = 0; m_lv = 0; m_leds = 0;
         held = 0; streak = 0; nacc = 0; sum = 0;
         due_q.delete(); mean_q.delete();
      end else begin
         m_lv = 0;
         if (due_q.size() > 0 && due_q[0] == cyc) begin
            m_level = mean_q[0];
            void'(due_q.pop_front());
            void'(mean_q.pop_front());
            n = (m_level + 4095) / 4096;
            if (n > 8) n = 8;
            if (n >= held) begin
               held = n; streak = 0;
            end else if (streak == 3) begin
               held = held - 1; streak = 0;
            end else begin
               streak++;
            end
            m_leds = (1 << held) - 1;
            m_lv = 1;
         end
         if (sample_valid && enable) begin
            sum += mag_of(audio_in);
            nacc++;
            if (nacc == 4) begin
               due_q.push_back(cyc + 2);
               mean_q.push_back(sum / 4);
               nacc = 0; sum = 0;
            end
         end
      end
   end

   // Per-cycle compare against the model, away from the active edge
   always @(negedge clk) begin
      if (level_valid) lv_count++;
      if (chk_en) begin
         check("level", int'(level), m_level);
         check("level_valid", int'(level_valid), m_lv);
         check("leds", int'(leds), m_leds);
      end
   end

   task automatic drive(input logic [15:0] v, input logic sv, input logic en);
      @(negedge clk);
      audio_in = v; sample_valid = sv; enable = en;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(16'd0, 1'b0, 1'b1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0; sample_valid = 1'b0; enable = 1'b1;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      lv_count = 0;
   endtask

   initial begin
      logic [15:0] t2 [4];
      t2[0] = 16'h8000; t2[1] = 16'h7FFF; t2[2] = 16'hFFFF; t2[3] = 16'h0001;

      do_reset();
      chk_en = 1'b1;
      check("reset_level", int'(level), 0);
      check("reset_leds", int'(leds), 0);

      // 1: four +8192 samples
      for (int i = 0; i < 4; i++) drive(16'd8192, 1'b1, 1'b1);
      idle(4);
      check("t1_level", int'(level), 8192);
      check("t1_leds", int'(leds), 8'h03);
      check("t1_pulses", lv_count, 1);

      // 2: saturating magnitudes
      do_reset();
      for (int i = 0; i < 4; i++) drive(t2[i], 1'b1, 1'b1);
      idle(4);
      check("t2_level", int'(level), 16384);
      check("t2_leds", int'(leds), 8'h0F);

      // 3: peak hold and decay
      do_reset();
      for (int i = 0; i < 4; i++) drive(16'd32767, 1'b1, 1'b1);
      idle(3);
      check("t3_full", int'(leds), 8'hFF);
      for (int w = 1; w <= 8; w++) begin
         for (int i = 0; i < 4; i++) drive(16'd0, 1'b1, 1'b1);
         idle(3);
         check("t3_decay", int'(leds), (w < 4) ? 8'hFF : ((w < 8) ? 8'h7F : 8'h3F));
      end

      // 4: enable low ignores strobes
      do_reset();
      drive(16'd100, 1'b1, 1'b1);
      drive(16'd200, 1'b1, 1'b1);
      for (int i = 0; i < 10; i++) drive(16'd30000, 1'b1, 1'b0);
      drive(16'd300, 1'b1, 1'b1);
      drive(16'd400, 1'b1, 1'b1);
      idle(5);
      check("t4_pulses", lv_count, 1);
      check("t4_level", int'(level), 250);

      // 5: strobe during UPDATE belongs to the next window
      do_reset();
      for (int i = 0; i < 4; i++) drive(16'd4096, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) drive(16'd20000, 1'b1, 1'b1);
      idle(5);
      check("t5_pulses", lv_count, 2);
      check("t5_level", int'(level), 20000);

      // 6: reset mid-window discards the partial window
      do_reset();
      for (int i = 0; i < 3; i++) drive(16'd30000, 1'b1, 1'b1);
      do_reset();
      check("t6_rst_level", int'(level), 0);
      check("t6_rst_leds", int'(leds), 0);
      for (int i = 0; i < 4; i++) drive(16'd12288, 1'b1, 1'b1);
      idle(4);
      check("t6_level", int'(level), 12288);
      check("t6_leds", int'(leds), 8'h07);

      // Randomised traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         reset_n      = ($urandom_range(0, 199) != 0);
         enable       = ($urandom_range(0, 3) != 0);
         sample_valid = ($urandom_range(0, 2) != 0);
         case ($urandom_range(0, 3))
            0: audio_in = 16'h8000;
            1: audio_in = 16'($urandom_range(0, 2047));
            default: audio_in = 16'($urandom);
         endcase
      end
      idle(6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
